// File: rtl/snake_pkg.sv
// Shared types for the snake game blocks.
//   game_mode_t : display/generator mode driven by game_ctrl.
package snake_pkg;

  typedef enum logic [1:0] {
    MENU = 2'd0,
    GAME = 2'd1,
    END  = 2'd2
  } game_mode_t;

endpackage

// File: rtl/click_edge.sv
// Rising-edge detector for a mouse button level.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   level : button level
//   pulse : high for the cycle where level is high and was low the cycle before
// The previous-level flop resets to 1, so a button held through reset gives no click.
module click_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic prev_q, prev_d;

  assign prev_d = level;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  // Combinational so the FSM reacts on the same edge that first samples the press.
  assign pulse = level & ~prev_q;

endmodule

// File: rtl/game_ctrl.sv
// Game flow controller: menu, countdown, run, pause and game-over.
//   clk, rst      : system clock, synchronous active-high reset
//   tick          : one-cycle game-step pulse
//   left, right   : mouse button levels (clicked on rising edge)
//   collision     : head hit wall or body
//   point_eaten   : one-cycle pulse per consumed point
//   mode          : MENU / GAME / END
//   move_en       : move stage may advance (run state only)
//   map_rst       : one-cycle pulse reinitialising map and snake at game start
//   score         : two BCD digits {tens, ones}, saturating at 99
//   countdown     : remaining pre-game countdown
//   paused        : game is paused
// All outputs are registered and change on the edge that samples their cause.
module game_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned COUNT_TICKS = 3,
  parameter int unsigned OVER_TICKS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       left,
  input  logic       right,
  input  logic       collision,
  input  logic       point_eaten,
  output game_mode_t mode,
  output logic       move_en,
  output logic       map_rst,
  output logic [7:0] score,
  output logic [1:0] countdown,
  output logic       paused
);

  localparam logic [1:0] CdInit   = 2'(COUNT_TICKS);
  localparam logic [3:0] OverInit = 4'(OVER_TICKS);

  typedef enum logic [2:0] {
    S_MENU  = 3'd0,
    S_COUNT = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] score_q, score_d;
  logic [1:0] cd_q, cd_d;
  logic [3:0] over_q, over_d;
  logic       map_rst_q, map_rst_d;
  game_mode_t mode_q, mode_d;
  logic       move_en_q, move_en_d;
  logic       paused_q, paused_d;

  logic click_l, click_r;

  click_edge u_edge_l (
    .clk   (clk),
    .rst   (rst),
    .level (left),
    .pulse (click_l)
  );

  click_edge u_edge_r (
    .clk   (clk),
    .rst   (rst),
    .level (right),
    .pulse (click_r)
  );

  // BCD increment with saturation at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99) begin
      return v;
    end else if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_MENU;
      score_q   <= 8'h00;
      cd_q      <= 2'd0;
      over_q    <= 4'd0;
      map_rst_q <= 1'b0;
      mode_q    <= MENU;
      move_en_q <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      cd_q      <= cd_d;
      over_q    <= over_d;
      map_rst_q <= map_rst_d;
      mode_q    <= mode_d;
      move_en_q <= move_en_d;
      paused_q  <= paused_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    cd_d      = cd_q;
    over_d    = over_q;
    map_rst_d = 1'b0;
    unique case (state_q)
      S_MENU: begin
        if (click_l) begin
          state_d   = S_COUNT;
          map_rst_d = 1'b1;
          score_d   = 8'h00;
          cd_d      = CdInit;
        end
      end
      S_COUNT: begin
        if (tick) begin
          if (cd_q == 2'd1) begin
            cd_d    = 2'd0;
            state_d = S_RUN;
          end else begin
            cd_d = cd_q - 2'd1;
          end
        end
      end
      S_RUN: begin
        // Collision has priority, so a point eaten on the fatal step is not scored.
        if (collision) begin
          state_d = S_OVER;
          over_d  = OverInit;
        end else if (click_r) begin
          state_d = S_PAUSE;
        end else if (point_eaten) begin
          score_d = bcd_inc(score_q);
        end
      end
      S_PAUSE: begin
        if (click_r) begin
          state_d = S_RUN;
        end
      end
      S_OVER: begin
        // Counter holds at zero; restart is only accepted once it got there.
        if (over_q == 4'd0) begin
          if (click_l) begin
            state_d = S_MENU;
          end
        end else if (tick) begin
          over_d = over_q - 4'd1;
        end
      end
      default: state_d = S_MENU;
    endcase
  end

  // Outputs decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    mode_d    = GAME;
    move_en_d = 1'b0;
    paused_d  = 1'b0;
    unique case (state_d)
      S_MENU:  mode_d = MENU;
      S_OVER:  mode_d = END;
      S_RUN:   move_en_d = 1'b1;
      S_PAUSE: paused_d = 1'b1;
      default: mode_d = GAME;
    endcase
  end

  assign mode      = mode_q;
  assign move_en   = move_en_q;
  assign map_rst   = map_rst_q;
  assign score     = score_q;
  assign countdown = cd_q;
  assign paused    = paused_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: a behavioural model predicts every cycle's outputs,
// predictions go through a queue and are compared once the DUT has clocked.
module tb_game_ctrl;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic       collision = 1'b0;
  logic       point_eaten = 1'b0;
  game_mode_t mode;
  logic       move_en, map_rst, paused;
  logic [7:0] score;
  logic [1:0] countdown;

  game_ctrl #(
    .COUNT_TICKS (3),
    .OVER_TICKS  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .left        (left),
    .right       (right),
    .collision   (collision),
    .point_eaten (point_eaten),
    .mode        (mode),
    .move_en     (move_en),
    .map_rst     (map_rst),
    .score       (score),
    .countdown   (countdown),
    .paused      (paused)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] mode;
    logic       move_en;
    logic       map_rst;
    logic [7:0] score;
    logic [1:0] countdown;
    logic       paused;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Model: states 0 menu, 1 count, 2 run, 3 pause, 4 over; score kept as an integer.
  int   m_state = 0;
  int   m_score = 0;
  int   m_cd = 0;
  int   m_over = 0;
  bit   m_pl = 1'b1;
  bit   m_pr = 1'b1;
  bit   m_map_rst = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit t, input bit l, input bit rr, input bit c,
                            input bit p);
    bit cl, cr;
    if (r) begin
      m_state = 0; m_score = 0; m_cd = 0; m_over = 0;
      m_pl = 1'b1; m_pr = 1'b1; m_map_rst = 1'b0;
    end else begin
      cl = l && !m_pl;
      cr = rr && !m_pr;
      m_pl = l;
      m_pr = rr;
      m_map_rst = 1'b0;
      case (m_state)
        0: if (cl) begin
          m_state = 1; m_map_rst = 1'b1; m_score = 0; m_cd = 3;
        end
        1: if (t) begin
          m_cd--;
          if (m_cd == 0) m_state = 2;
        end
        2: if (c) begin
          m_state = 4; m_over = 8;
        end else if (cr) begin
          m_state = 3;
        end else if (p && m_score < 99) begin
          m_score++;
        end
        3: if (cr) m_state = 2;
        4: if (m_over == 0) begin
          if (cl) m_state = 0;
        end else if (t) begin
          m_over--;
        end
        default: m_state = 0;
      endcase
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.mode      = (m_state == 0) ? 2'd0 : (m_state == 4) ? 2'd2 : 2'd1;
    e.move_en   = (m_state == 2);
    e.paused    = (m_state == 3);
    e.map_rst   = m_map_rst;
    e.score     = 8'(((m_score / 10) * 16) + (m_score % 10));
    e.countdown = 2'(m_cd);
    return e;
  endfunction

  task automatic cycle(input bit r, input bit t, input bit l, input bit rr, input bit c,
                       input bit p);
    exp_t e;
    @(negedge clk);
    rst = r; tick = t; left = l; right = rr; collision = c; point_eaten = p;
    model_step(r, t, l, rr, c, p);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("mode", mode, e.mode);
    check_eq("move_en", move_en, e.move_en);
    check_eq("map_rst", map_rst, e.map_rst);
    check_eq("score", score, e.score);
    check_eq("countdown", countdown, e.countdown);
    check_eq("paused", paused, e.paused);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic press_left();
    cycle(0, 0, 1, 0, 0, 0);
  endtask

  task automatic press_right();
    cycle(0, 0, 0, 1, 0, 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      cycle(0, 1, 0, 0, 0, 0);
      idle(1);
    end
  endtask

  task automatic eat(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    // Reset with left held, then keep holding after release: no click.
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    check_eq("rst_mode", mode, MENU);
    check_eq("rst_score", score, 8'h00);
    check_eq("rst_cd", countdown, 2'd0);
    repeat (3) cycle(0, 0, 1, 0, 0, 0);
    check_eq("held_mode", mode, MENU);
    check_eq("held_map_rst", map_rst, 1'b0);

    // Release and press: game starts.
    idle(1);
    press_left();
    check_eq("start_map_rst", map_rst, 1'b1);
    check_eq("start_mode", mode, GAME);
    check_eq("start_cd", countdown, 2'd3);
    idle(1);
    check_eq("map_rst_once", map_rst, 1'b0);
    ticks(2);
    check_eq("cd_after2", countdown, 2'd1);
    check_eq("no_move_yet", move_en, 1'b0);
    ticks(1);
    check_eq("run_move_en", move_en, 1'b1);
    check_eq("run_cd", countdown, 2'd0);

    // Scoring and saturation.
    eat(12);
    check_eq("score_12", score, 8'h12);
    eat(87);
    check_eq("score_99", score, 8'h99);
    eat(1);
    check_eq("score_sat", score, 8'h99);

    // Pause ignores collision, points and ticks.
    press_right();
    check_eq("pause_paused", paused, 1'b1);
    check_eq("pause_move_en", move_en, 1'b0);
    cycle(0, 1, 0, 0, 1, 1);
    check_eq("pause_coll_mode", mode, GAME);
    check_eq("pause_coll_paused", paused, 1'b1);
    idle(1);
    press_right();
    check_eq("resume_move_en", move_en, 1'b1);
    check_eq("resume_paused", paused, 1'b0);

    // Collision with point: game over, score frozen.
    cycle(0, 0, 0, 0, 1, 1);
    check_eq("over_mode", mode, END);
    check_eq("over_score", score, 8'h99);

    // Restart only after the full over-tick count.
    ticks(7);
    press_left();
    check_eq("early_click", mode, END);
    idle(1);
    ticks(1);
    press_left();
    check_eq("restart_mode", mode, MENU);

    // New game to score 05, then collision + point together.
    idle(1);
    press_left();
    check_eq("new_score_clr", score, 8'h00);
    idle(1);
    ticks(3);
    eat(5);
    cycle(0, 0, 0, 0, 1, 1);
    check_eq("tie_mode", mode, END);
    check_eq("tie_score", score, 8'h05);
    check_eq("tie_move_en", move_en, 1'b0);

    // Reset mid-game aborts without a map_rst pulse.
    ticks(8);
    press_left();
    idle(1);
    press_left();
    idle(1);
    ticks(3);
    eat(2);
    cycle(1, 0, 0, 0, 0, 0);
    check_eq("mid_rst_mode", mode, MENU);
    check_eq("mid_rst_score", score, 8'h00);
    check_eq("mid_rst_map_rst", map_rst, 1'b0);
    check_eq("mid_rst_move_en", move_en, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
